// File: rtl/ber_mon_pkg.sv
// ---------------------------------------------------------------------------
// ber_mon_pkg
// Shared definitions for the multi-channel BER monitor:
//   lane_state_e : per-lane FSM state (FILL, SEARCH, COUNT)
//   RESYNC_W     : width of the per-lane loss-of-sync event counter
//   sat_inc      : saturating increment on values up to 64 bits wide
// ---------------------------------------------------------------------------
package ber_mon_pkg;

   typedef enum logic [1:0] {
      ST_FILL   = 2'd0,
      ST_SEARCH = 2'd1,
      ST_COUNT  = 2'd2
   } lane_state_e;

   localparam int RESYNC_W = 8;

   // Callers zero-extend the operand and pass their own all-ones ceiling, so
   // one function serves every counter width up to 64.
   function automatic logic [63:0] sat_inc(input logic [63:0] value,
                                           input logic [63:0] max_value);
      return (value >= max_value) ? max_value : value + 64'd1;
   endfunction

endpackage

// File: rtl/ber_monitor_mc_if.sv
// ---------------------------------------------------------------------------
// ber_monitor_mc_if
// Bit stream and status bundle of the BER monitor.
//   i_enable     : bit strobe shared by all lanes
//   i_tx_bits    : reference bit per lane
//   i_rx_bits    : received bit per lane
//   i_clear      : synchronous clear of error/total/resync counters
//   o_locked     : lane is counting
//   o_ber_ok     : last counting window was within the OK threshold
//   o_latency    : locked latency per lane (LW bits each)
//   o_err_cnt    : accumulated errors per lane (NB_CNT bits each)
//   o_tot_cnt    : accumulated compared bits per lane (NB_CNT bits each)
//   o_resync_cnt : loss-of-sync events per lane (RESYNC_W bits each)
// master drives the stream, slave is the monitor.
// ---------------------------------------------------------------------------
interface ber_monitor_mc_if #(
   parameter int NCH    = 2,
   parameter int LW     = 9,
   parameter int NB_CNT = 64
);
   import ber_mon_pkg::*;

   logic                       i_enable;
   logic [NCH-1:0]             i_tx_bits;
   logic [NCH-1:0]             i_rx_bits;
   logic                       i_clear;
   logic [NCH-1:0]             o_locked;
   logic [NCH-1:0]             o_ber_ok;
   logic [NCH*LW-1:0]          o_latency;
   logic [NCH*NB_CNT-1:0]      o_err_cnt;
   logic [NCH*NB_CNT-1:0]      o_tot_cnt;
   logic [NCH*RESYNC_W-1:0]    o_resync_cnt;

   modport master (
      output i_enable, i_tx_bits, i_rx_bits, i_clear,
      input  o_locked, o_ber_ok, o_latency, o_err_cnt, o_tot_cnt, o_resync_cnt
   );

   modport slave (
      input  i_enable, i_tx_bits, i_rx_bits, i_clear,
      output o_locked, o_ber_ok, o_latency, o_err_cnt, o_tot_cnt, o_resync_cnt
   );

endinterface

// File: rtl/ber_mon_lane.sv
// ---------------------------------------------------------------------------
// ber_mon_lane
// One BER lane: tx history buffer, latency search FSM and counters.
//   clk, rst       : clock, asynchronous active-high reset
//   i_enable       : bit strobe
//   i_clear        : clears error/total/resync counters (wins over i_enable)
//   i_tx, i_rx     : reference and received bit
//   o_locked       : lane in COUNT
//   o_ber_ok       : last COUNT window had errors <= OK_THR
//   o_latency      : locked latency
//   o_err_cnt      : saturating error count
//   o_tot_cnt      : saturating compared-bit count
//   o_resync_cnt   : saturating loss-of-sync count
// Optional feature macro: BER_LOS_RESYNC_EN (re-search on loss of sync).
// Counter widths above 64 bits are not supported by sat_inc.
// ---------------------------------------------------------------------------
module ber_mon_lane
   import ber_mon_pkg::*;
#(
   parameter int MAX_LAT = 512,
   parameter int WIN     = 511,
   parameter int NB_CNT  = 64,
   parameter int LOS_THR = 128,
   parameter int OK_THR  = 0
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       i_enable,
   input  logic                       i_clear,
   input  logic                       i_tx,
   input  logic                       i_rx,
   output logic                       o_locked,
   output logic                       o_ber_ok,
   output logic [$clog2(MAX_LAT)-1:0] o_latency,
   output logic [NB_CNT-1:0]          o_err_cnt,
   output logic [NB_CNT-1:0]          o_tot_cnt,
   output logic [RESYNC_W-1:0]        o_resync_cnt
);
   localparam int LW = $clog2(MAX_LAT);
   localparam int WW = $clog2(WIN + 1);
   // One spare bit keeps the all-ones best_err start value above any window count.
   localparam int EW = WW + 1;
   localparam logic [63:0] CNT_MAX = (NB_CNT >= 64) ? {64{1'b1}}
                                                     : ((64'd1 << NB_CNT) - 64'd1);

   lane_state_e        state;
   logic [MAX_LAT-1:0] tx_buf;
   logic [LW-1:0]      wr_ptr;
   logic [LW-1:0]      fill_cnt;
   logic [LW-1:0]      cand;
   logic [LW-1:0]      best_lat;
   logic [WW-1:0]      win_cnt;
   logic [EW-1:0]      err_win;
   logic [EW-1:0]      best_err;

   logic               tx_d;
   logic               mis;
   logic               win_end;
   logic [EW-1:0]      err_now;
   logic [LW-1:0]      lock_lat;

   // cand doubles as the locked latency while counting. Delay 0 is the
   // bit on the input now; older bits come from the buffer.
   assign tx_d     = (cand == '0) ? i_tx : tx_buf[wr_ptr - cand];
   assign mis      = i_rx ^ tx_d;
   assign err_now  = err_win + EW'(mis);
   assign win_end  = (win_cnt == WW'(WIN - 1));
   assign lock_lat = (err_now < best_err) ? cand : best_lat;

`ifdef BER_LOS_RESYNC_EN
   localparam logic [63:0] RS_MAX = (64'd1 << RESYNC_W) - 64'd1;
   logic [RESYNC_W-1:0] resync_q;
   assign o_resync_cnt = resync_q;
`else
   assign o_resync_cnt = '0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_FILL;
         tx_buf    <= '0;
         wr_ptr    <= '0;
         fill_cnt  <= '0;
         cand      <= '0;
         best_lat  <= '0;
         best_err  <= '1;
         win_cnt   <= '0;
         err_win   <= '0;
         o_locked  <= 1'b0;
         o_ber_ok  <= 1'b0;
         o_latency <= '0;
         o_err_cnt <= '0;
         o_tot_cnt <= '0;
`ifdef BER_LOS_RESYNC_EN
         resync_q  <= '0;
`endif
      end else begin
         if (i_enable) begin
            tx_buf[wr_ptr] <= i_tx;
            wr_ptr         <= wr_ptr + 1'b1;

            // Window bookkeeping runs the same way in SEARCH and COUNT.
            if (state != ST_FILL) begin
               if (win_end) begin
                  win_cnt <= '0;
                  err_win <= '0;
               end else begin
                  win_cnt <= win_cnt + 1'b1;
                  err_win <= err_now;
               end
            end

            case (state)
               ST_FILL: begin
                  fill_cnt <= fill_cnt + 1'b1;
                  if (fill_cnt == LW'(MAX_LAT - 1)) begin
                     state    <= ST_SEARCH;
                     cand     <= '0;
                     best_err <= '1;
                     win_cnt  <= '0;
                     err_win  <= '0;
                  end
               end

               ST_SEARCH: begin
                  if (win_end) begin
                     if (err_now == '0) begin
                        state     <= ST_COUNT;
                        o_locked  <= 1'b1;
                        o_latency <= cand;
                     end else begin
                        if (err_now < best_err) begin
                           best_err <= err_now;
                           best_lat <= cand;
                        end
                        if (cand == '1) begin
                           state     <= ST_COUNT;
                           o_locked  <= 1'b1;
                           o_latency <= lock_lat;
                           cand      <= lock_lat;
                        end else begin
                           cand <= cand + 1'b1;
                        end
                     end
                  end
               end

               ST_COUNT: begin
                  o_tot_cnt <= NB_CNT'(sat_inc(64'(o_tot_cnt), CNT_MAX));
                  if (mis) o_err_cnt <= NB_CNT'(sat_inc(64'(o_err_cnt), CNT_MAX));
                  if (win_end) begin
                     o_ber_ok <= (int'(err_now) <= OK_THR);
`ifdef BER_LOS_RESYNC_EN
                     if (int'(err_now) > LOS_THR) begin
                        state    <= ST_SEARCH;
                        cand     <= '0;
                        best_err <= '1;
                        o_locked <= 1'b0;
                        o_ber_ok <= 1'b0;
                        resync_q <= RESYNC_W'(sat_inc(64'(resync_q), RS_MAX));
                     end
`endif
                  end
               end

               default: state <= ST_FILL;
            endcase
         end

         // Clear overrides any increment from a coincident enable.
         if (i_clear) begin
            o_err_cnt <= '0;
            o_tot_cnt <= '0;
`ifdef BER_LOS_RESYNC_EN
            resync_q  <= '0;
`endif
         end
      end
   end

endmodule

// File: rtl/ber_monitor_mc.sv
// ---------------------------------------------------------------------------
// ber_monitor_mc
// Multi-channel BER monitor: NCH independent lanes sharing one bit strobe.
//   clk     : system clock
//   i_reset : asynchronous active-high reset
//   bus     : ber_monitor_mc_if.slave (stream in, per-lane status out)
// Optional feature macro: BER_LOS_RESYNC_EN (loss-of-sync re-search).
// ---------------------------------------------------------------------------
module ber_monitor_mc
   import ber_mon_pkg::*;
#(
   parameter int NCH     = 2,
   parameter int MAX_LAT = 512,
   parameter int WIN     = 511,
   parameter int NB_CNT  = 64,
   parameter int LOS_THR = 128,
   parameter int OK_THR  = 0
) (
   input  logic             clk,
   input  logic             i_reset,
   ber_monitor_mc_if.slave  bus
);
   localparam int LW = $clog2(MAX_LAT);

   logic [NCH-1:0]          locked;
   logic [NCH-1:0]          ber_ok;
   logic [NCH*LW-1:0]       latency;
   logic [NCH*NB_CNT-1:0]   err_cnt;
   logic [NCH*NB_CNT-1:0]   tot_cnt;
   logic [NCH*RESYNC_W-1:0] resync_cnt;

   for (genvar g = 0; g < NCH; g++) begin : g_lane
      ber_mon_lane #(
         .MAX_LAT (MAX_LAT),
         .WIN     (WIN),
         .NB_CNT  (NB_CNT),
         .LOS_THR (LOS_THR),
         .OK_THR  (OK_THR)
      ) u_lane (
         .clk          (clk),
         .rst          (i_reset),
         .i_enable     (bus.i_enable),
         .i_clear      (bus.i_clear),
         .i_tx         (bus.i_tx_bits[g]),
         .i_rx         (bus.i_rx_bits[g]),
         .o_locked     (locked[g]),
         .o_ber_ok     (ber_ok[g]),
         .o_latency    (latency[g*LW +: LW]),
         .o_err_cnt    (err_cnt[g*NB_CNT +: NB_CNT]),
         .o_tot_cnt    (tot_cnt[g*NB_CNT +: NB_CNT]),
         .o_resync_cnt (resync_cnt[g*RESYNC_W +: RESYNC_W])
      );
   end

   assign bus.o_locked     = locked;
   assign bus.o_ber_ok     = ber_ok;
   assign bus.o_latency    = latency;
   assign bus.o_err_cnt    = err_cnt;
   assign bus.o_tot_cnt    = tot_cnt;
   assign bus.o_resync_cnt = resync_cnt;

endmodule

// File: tb/tb_ber_monitor_mc.sv
// ---------------------------------------------------------------------------
// tb_ber_monitor_mc
// Randomized bench for ber_monitor_mc with a reduced search depth and window.
// The reference model replays the recorded bit history and derives each
// lane's expected status by evaluating whole search and count windows.
// ---------------------------------------------------------------------------
module tb_ber_monitor_mc;
   import ber_mon_pkg::*;

   localparam int NCH     = 2;
   localparam int MAX_LAT = 64;
   localparam int LW      = 6;
   localparam int WIN     = 63;
   localparam int NB_CNT  = 64;
   localparam int LOS_THR = 8;
   localparam int OK_THR  = 0;
   localparam int MAXN    = 12000;
   localparam int VW      = 8 + 1 + 1 + LW + 2 * NB_CNT;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   ber_monitor_mc_if #(.NCH(NCH), .LW(LW), .NB_CNT(NB_CNT)) bif ();

   ber_monitor_mc #(
      .NCH(NCH), .MAX_LAT(MAX_LAT), .WIN(WIN), .NB_CNT(NB_CNT),
      .LOS_THR(LOS_THR), .OK_THR(OK_THR)
   ) dut (
      .clk     (clk),
      .i_reset (rst),
      .bus     (bif)
   );

   int       n_vec = 0;
   int       n_bad = 0;
   int       n_en  = 0;
   bit       tx_h  [NCH][MAXN+1];
   bit       rx_h  [NCH][MAXN+1];
   bit       clr_h [MAXN+1];
   int       lat_cfg   [NCH];
   int       noise_div [NCH];
   logic [8:0] prbs = 9'h1FF;

   // ---------------- reference model ----------------
   function automatic int mis(input int l, input int n, input int c);
      return int'(rx_h[l][n] ^ tx_h[l][n-c]);
   endfunction

   function automatic logic [VW-1:0] pack(input int rs, input bit locked, input bit ok,
                                          input int lat, input logic [63:0] err,
                                          input logic [63:0] tot);
      return {8'(rs), locked, ok, LW'(lat), err, tot};
   endfunction

   function automatic logic [VW-1:0] predict(input int l);
      int pos, best, bl, lat, rs, e, hi, last;
      bit locked, ok;
      logic [63:0] err, tot;
      last = n_en; err = 0; tot = 0; rs = 0; lat = 0; locked = 0; ok = 0;
      if (last < MAX_LAT) return pack(rs, locked, ok, lat, err, tot);
      pos = MAX_LAT;
      while (1'b1) begin
         best = 1 << 30; bl = 0;
         for (int c = 0; c < MAX_LAT; c++) begin
            hi = (pos + WIN > last) ? last : pos + WIN;
            e = 0;
            for (int n = pos + 1; n <= hi; n++) begin
               e += mis(l, n, c);
               if (clr_h[n]) begin err = 0; tot = 0; rs = 0; end
            end
            if (pos + WIN > last) return pack(rs, locked, ok, lat, err, tot);
            pos += WIN;
            if (e == 0) begin lat = c; break; end
            if (e < best) begin best = e; bl = c; end
            if (c == MAX_LAT - 1) lat = bl;
         end
         locked = 1; ok = 0;
         while (1'b1) begin
            hi = (pos + WIN > last) ? last : pos + WIN;
            e = 0;
            for (int n = pos + 1; n <= hi; n++) begin
               e += mis(l, n, lat);
               if (clr_h[n]) begin err = 0; tot = 0; rs = 0; end
               else begin tot += 1; err += 64'(mis(l, n, lat)); end
            end
            if (pos + WIN > last) return pack(rs, locked, ok, lat, err, tot);
            pos += WIN;
            ok = (e <= OK_THR);
`ifdef BER_LOS_RESYNC_EN
            if (e > LOS_THR) begin
               rs = (rs < 255) ? rs + 1 : 255;
               locked = 0; ok = 0;
               break;
            end
`endif
         end
      end
      return pack(rs, locked, ok, lat, err, tot);
   endfunction

   function automatic logic [VW-1:0] dut_vec(input int l);
      return {bif.o_resync_cnt[l*8 +: 8], bif.o_locked[l], bif.o_ber_ok[l],
              bif.o_latency[l*LW +: LW], bif.o_err_cnt[l*NB_CNT +: NB_CNT],
              bif.o_tot_cnt[l*NB_CNT +: NB_CNT]};
   endfunction

   // ---------------- stimulus ----------------
   task automatic drive(input bit en, input bit clr, input logic [NCH-1:0] flip);
      logic [NCH-1:0] txv, rxv;
      bit t, r;
      @(negedge clk);
      txv = NCH'($urandom);
      rxv = NCH'($urandom);
      if (en) begin
         if (n_en >= MAXN) begin
            $display("FAIL history_overflow n=%0d limit=%0d", n_en, MAXN);
            $fatal(1, "history overflow");
         end
         n_en++;
         for (int l = 0; l < NCH; l++) begin
            if (l == 0) begin
               t = prbs[8] ^ prbs[4];
               prbs = {prbs[7:0], t};
            end else begin
               t = 1'($urandom);
            end
            tx_h[l][n_en] = t;
            r = (n_en > lat_cfg[l]) ? tx_h[l][n_en - lat_cfg[l]] : 1'b0;
            if (noise_div[l] != 0 && $urandom_range(noise_div[l] - 1) == 0) r = ~r;
            if (flip[l]) r = ~r;
            rx_h[l][n_en] = r;
            txv[l] = t;
            rxv[l] = r;
         end
         clr_h[n_en] = clr;
      end
      bif.i_enable  = en;
      bif.i_clear   = clr & en;
      bif.i_tx_bits = txv;
      bif.i_rx_bits = rxv;
      @(posedge clk);
      #1;
   endtask

   task automatic run_to(input int target);
      for (int k = 0; k < 100000 && n_en < target; k++)
         drive($urandom_range(3) != 0, 1'b0, '0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      n_en = 0;
      prbs = 9'h1FF;
      bif.i_enable = 1'b0;
      bif.i_clear  = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      logic [VW-1:0] act;
      bif.i_enable = 1'b0; bif.i_clear = 1'b0; bif.i_tx_bits = '0; bif.i_rx_bits = '0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      for (int l = 0; l < NCH; l++) begin
         act = dut_vec(l);
         n_vec++;
         if (act !== '0) begin
            n_bad++;
            $display("FAIL reset_state lane%0d got %h want 0", l, act);
         end
      end
      do_reset();
   endtask

   task automatic test_prbs_lock();
      int pts[5] = '{441, 442, 2457, 2458, 2521};
      logic [VW-1:0] act, exp_v;
      lat_cfg   = '{37, 5};
      noise_div = '{0, 0};
      foreach (pts[i]) begin
         run_to(pts[i]);
         for (int l = 0; l < NCH; l++) begin
            act = dut_vec(l); exp_v = predict(l);
            n_vec++;
            if (act !== exp_v) begin
               n_bad++;
               $display("FAIL prbs_lock lane%0d n=%0d got %h want %h", l, n_en, act, exp_v);
            end
         end
         n_vec++;
         if (pts[i] == 442 && bif.o_locked !== 2'b10) begin
            n_bad++;
            $display("FAIL lane1_lock_time locked got %b want 10", bif.o_locked);
         end else if (pts[i] == 2458 && {bif.o_locked[0], bif.o_latency[LW-1:0]} !== {1'b1, 6'd37}) begin
            n_bad++;
            $display("FAIL lane0_lock locked/lat got %b/%0d want 1/37",
                     bif.o_locked[0], bif.o_latency[LW-1:0]);
         end else if (pts[i] == 2521 && {bif.o_ber_ok[0], bif.o_err_cnt[63:0]} !== {1'b1, 64'd0}) begin
            n_bad++;
            $display("FAIL lane0_ber_ok ok/err got %b/%0d want 1/0",
                     bif.o_ber_ok[0], bif.o_err_cnt[63:0]);
         end
      end
   endtask

   task automatic test_errors();
      logic [VW-1:0] act, exp_v, base;
      int injected = 0;
      base = predict(0);
      for (int k = 0; k < 1000; k++) begin
         if ($urandom_range(4) == 0) drive(1'b0, 1'b0, '0);
         drive(1'b1, 1'b0, (k % 100 == 50) ? 2'b01 : 2'b00);
         if (k % 100 == 50) injected++;
         if (k % 100 == 99) begin
            for (int l = 0; l < NCH; l++) begin
               act = dut_vec(l); exp_v = predict(l);
               n_vec++;
               if (act !== exp_v) begin
                  n_bad++;
                  $display("FAIL errors lane%0d n=%0d got %h want %h", l, n_en, act, exp_v);
               end
            end
         end
      end
      n_vec++;
      if (bif.o_err_cnt[63:0] !== base[2*NB_CNT-1:NB_CNT] + 64'(injected) ||
          bif.o_tot_cnt[63:0] !== base[NB_CNT-1:0] + 64'd1000) begin
         n_bad++;
         $display("FAIL err_tot_delta err/tot got %0d/%0d want %0d/%0d",
                  bif.o_err_cnt[63:0], bif.o_tot_cnt[63:0],
                  base[2*NB_CNT-1:NB_CNT] + 64'(injected), base[NB_CNT-1:0] + 64'd1000);
      end
   endtask

   task automatic test_clear();
      logic [VW-1:0] act, exp_v;
      drive(1'b1, 1'b1, '0);
      n_vec++;
      if ({bif.o_err_cnt, bif.o_tot_cnt} !== '0 || bif.o_locked !== 2'b11 ||
          bif.o_latency[LW-1:0] !== 6'd37) begin
         n_bad++;
         $display("FAIL clear err=%h tot=%h locked=%b lat0=%0d want 0 0 11 37",
                  bif.o_err_cnt, bif.o_tot_cnt, bif.o_locked, bif.o_latency[LW-1:0]);
      end
      run_to(n_en + 20);
      for (int l = 0; l < NCH; l++) begin
         act = dut_vec(l); exp_v = predict(l);
         n_vec++;
         if (act !== exp_v) begin
            n_bad++;
            $display("FAIL after_clear lane%0d got %h want %h", l, act, exp_v);
         end
      end
   endtask

   task automatic test_invert();
      logic [VW-1:0] act, exp_v, base;
      base = predict(0);
      for (int k = 0; k < WIN; k++) drive(1'b1, 1'b0, 2'b01);
      run_to(n_en + 2 * WIN);
      for (int l = 0; l < NCH; l++) begin
         act = dut_vec(l); exp_v = predict(l);
         n_vec++;
         if (act !== exp_v) begin
            n_bad++;
            $display("FAIL invert lane%0d got %h want %h", l, act, exp_v);
         end
      end
`ifdef BER_LOS_RESYNC_EN
      run_to(n_en + 40 * WIN);
      act = dut_vec(0); exp_v = predict(0);
      n_vec++;
      if (act !== exp_v) begin
         n_bad++;
         $display("FAIL relock lane0 got %h want %h", act, exp_v);
      end
      n_vec++;
      if ({bif.o_resync_cnt[7:0], bif.o_locked[0], bif.o_latency[LW-1:0]} !== {8'd1, 1'b1, 6'd37}) begin
         n_bad++;
         $display("FAIL relock_state rs/locked/lat got %0d/%b/%0d want 1/1/37",
                  bif.o_resync_cnt[7:0], bif.o_locked[0], bif.o_latency[LW-1:0]);
      end
`else
      n_vec++;
      if ({bif.o_resync_cnt, bif.o_locked[0], bif.o_err_cnt[63:0]} !==
          {16'd0, 1'b1, base[2*NB_CNT-1:NB_CNT] + 64'd63}) begin
         n_bad++;
         $display("FAIL invert_nolos rs/locked/err got %h/%b/%0d want 0/1/%0d",
                  bif.o_resync_cnt, bif.o_locked[0], bif.o_err_cnt[63:0],
                  base[2*NB_CNT-1:NB_CNT] + 64'd63);
      end
`endif
   endtask

   task automatic test_two_lanes();
      int pts[3] = '{441, 442, 2000};
      logic [VW-1:0] act, exp_v;
      do_reset();
      lat_cfg   = '{5, 40};
      noise_div = '{0, 20};
      foreach (pts[i]) begin
         run_to(pts[i]);
         for (int l = 0; l < NCH; l++) begin
            act = dut_vec(l); exp_v = predict(l);
            n_vec++;
            if (act !== exp_v) begin
               n_bad++;
               $display("FAIL two_lanes lane%0d n=%0d got %h want %h", l, n_en, act, exp_v);
            end
         end
         n_vec++;
         if (pts[i] == 441 && bif.o_locked !== 2'b00) begin
            n_bad++;
            $display("FAIL early_lock locked got %b want 00", bif.o_locked);
         end else if (pts[i] == 442 && {bif.o_locked, bif.o_latency[LW-1:0]} !== {2'b01, 6'd5}) begin
            n_bad++;
            $display("FAIL lane0_first locked/lat0 got %b/%0d want 01/5",
                     bif.o_locked, bif.o_latency[LW-1:0]);
         end else if (pts[i] == 2000 && bif.o_locked !== 2'b01) begin
            n_bad++;
            $display("FAIL lane1_searching locked got %b want 01", bif.o_locked);
         end
      end
   endtask

   task automatic test_reset_mid_search();
      logic [VW-1:0] act, exp_v;
      int pts[4] = '{441, 442, 4095, 4096};
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      for (int l = 0; l < NCH; l++) begin
         act = dut_vec(l);
         n_vec++;
         if (act !== '0) begin
            n_bad++;
            $display("FAIL async_reset lane%0d got %h want 0", l, act);
         end
      end
      do_reset();
      foreach (pts[i]) begin
         run_to(pts[i]);
         for (int l = 0; l < NCH; l++) begin
            act = dut_vec(l); exp_v = predict(l);
            n_vec++;
            if (act !== exp_v) begin
               n_bad++;
               $display("FAIL research lane%0d n=%0d got %h want %h", l, n_en, act, exp_v);
            end
         end
      end
      n_vec++;
      if ({bif.o_locked[1], bif.o_latency[2*LW-1:LW]} !== {1'b1, 6'd40}) begin
         n_bad++;
         $display("FAIL lane1_best_lat locked/lat got %b/%0d want 1/40",
                  bif.o_locked[1], bif.o_latency[2*LW-1:LW]);
      end
   endtask

   initial begin
      lat_cfg   = '{0, 0};
      noise_div = '{0, 0};
      test_reset();
      test_prbs_lock();
      test_errors();
      test_clear();
      test_invert();
      test_two_lanes();
      test_reset_mid_search();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
